// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg: ALU control codes and multiplier sequencer state encoding.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package alu_pkg;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_XOR  = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SLL  = 3'b011;
    localparam logic [2:0] ALU_MUL  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SRAI = 3'b111;

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_BUSY = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

    // A one-iteration multiply still needs a 1-bit counter.
    function automatic int cnt_width(input int iter);
        return (iter > 1) ? $clog2(iter) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_shift_add_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mul_shift_add_step: one shift-add iteration, acc + a * b_bits.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mul_shift_add_step #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [WIDTH-1:0]          acc_i,
    input  logic [WIDTH-1:0]          a_i,
    input  logic [BITS_PER_CYCLE-1:0] b_bits_i,
    output logic [WIDTH-1:0]          acc_o
);

    logic [WIDTH-1:0] w_sum;

    always_comb begin
        w_sum = acc_i;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (b_bits_i[i]) begin
                w_sum = w_sum + (a_i << i);
            end
        end
        acc_o = w_sum;
    end

endmodule
`default_nettype wire

// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mul_seq_ctrl: EX-stage sequencer for the iterative shift-add MUL.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mul_seq_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [2:0]       ALUCtl_i,
    input  logic [WIDTH-1:0] rs1_data_i,
    input  logic [WIDTH-1:0] rs2_data_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int ITER  = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = cnt_width(ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               w_start;
    logic [WIDTH-1:0]   w_step_acc;

    mul_shift_add_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .acc_i    (acc_q),
        .a_i      (a_q),
        .b_bits_i (b_q[BITS_PER_CYCLE-1:0]),
        .acc_o    (w_step_acc)
    );

    // Only IDLE can start, so a MUL still held during DONE is never re-taken.
    assign w_start = valid_i && (ALUCtl_i == ALU_MUL) && !flush_i;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    a_d   = rs1_data_i;
                    b_d   = rs2_data_i;
                    acc_d = '0;
                    cnt_d = '0;
                    if ((rs1_data_i == '0) || (rs2_data_i == '0)) begin
                        state_d  = ST_DONE;
                        result_d = '0;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = w_step_acc;
                    a_d   = a_q << BITS_PER_CYCLE;
                    b_d   = b_q >> BITS_PER_CYCLE;
                    if (cnt_q == CNT_LAST) begin
                        state_d  = ST_DONE;
                        result_d = w_step_acc;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    assign stall_o  = ((state_q == ST_IDLE) && w_start) || (state_q == ST_BUSY);
    assign busy_o   = (state_q == ST_BUSY);
    assign done_o   = (state_q == ST_DONE);
    assign result_o = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mul_seq_ctrl: bench for mul_seq_ctrl at 1 and 4 bits per cycle.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mul_seq_ctrl;

    localparam logic [2:0] C_AND = 3'b000, C_XOR = 3'b001, C_ADD = 3'b010,
                           C_SLL = 3'b011, C_MUL = 3'b101, C_SUB = 3'b110,
                           C_SRAI = 3'b111;
    localparam int NOBS = 80;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [2];
    logic        valid [2];
    logic        flush [2];
    logic [2:0]  ctl   [2];
    logic [31:0] a_in  [2];
    logic [31:0] b_in  [2];
    logic        stall [2];
    logic        busy  [2];
    logic        done  [2];
    logic [31:0] res   [2];

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_dut
            mul_seq_ctrl #(
                .WIDTH          (32),
                .BITS_PER_CYCLE ((g == 0) ? 1 : 4)
            ) u_dut (
                .clk_i      (clk),
                .rst_i      (rst_n[g]),
                .valid_i    (valid[g]),
                .ALUCtl_i   (ctl[g]),
                .rs1_data_i (a_in[g]),
                .rs2_data_i (b_in[g]),
                .flush_i    (flush[g]),
                .stall_o    (stall[g]),
                .busy_o     (busy[g]),
                .done_o     (done[g]),
                .result_o   (res[g])
            );
        end
    endgenerate

    int checks = 0;
    int errors = 0;

    logic        obs_stall [NOBS];
    logic        obs_busy  [NOBS];
    logic        obs_done  [NOBS];
    logic [31:0] obs_res   [NOBS];

    function automatic int iter_of(input int d);
        return (d == 0) ? 32 : 8;
    endfunction

    // Cycles from start to DONE: zero operands short-circuit.
    function automatic int latency(input int d, input logic [31:0] a, input logic [31:0] b);
        return ((a == 0) || (b == 0)) ? 1 : iter_of(d) + 1;
    endfunction

    function automatic logic [31:0] product(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        return p[31:0];
    endfunction

    function automatic int count_done(input int n);
        int k = 0;
        for (int c = 0; c < n; c++) if (obs_done[c] === 1'b1) k++;
        return k;
    endfunction

    function automatic int first_done(input int n);
        for (int c = 0; c < n; c++) if (obs_done[c] === 1'b1) return c;
        return -1;
    endfunction

    function automatic int count_stall(input int n);
        int k = 0;
        for (int c = 0; c < n; c++) if (obs_stall[c] === 1'b1) k++;
        return k;
    endfunction

    // Presents one instruction from cycle 0; it leaves EX after DONE, flush or reset.
    task automatic drive_op(input int d, input logic [2:0] code, input logic [31:0] a,
                            input logic [31:0] b, input int flush_at, input int rst_at,
                            input int ncyc);
        bit alive = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            valid[d] = alive;
            ctl[d]   = code;
            a_in[d]  = a;
            b_in[d]  = b;
            flush[d] = (c == flush_at);
            rst_n[d] = (c != rst_at);
            @(negedge clk);
            obs_stall[c] = stall[d];
            obs_busy[c]  = busy[d];
            obs_done[c]  = done[d];
            obs_res[c]   = res[d];
            if (obs_done[c] === 1'b1) alive = 1'b0;
            if ((c == flush_at) || (c == rst_at)) alive = 1'b0;
            @(posedge clk);
            #1;
        end
        valid[d] = 1'b0;
        flush[d] = 1'b0;
        rst_n[d] = 1'b1;
    endtask

    task automatic test_reset(input int d);
        valid[d] = 1'b0;
        rst_n[d] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n[d] = 1'b1;
        @(negedge clk);
        checks++;
        if ({stall[d], busy[d], done[d]} !== 3'b000 || res[d] !== 32'd0) begin
            errors++;
            $display("FAIL reset d%0d: stall/busy/done=%b%b%b result=%h, required 000 and 0",
                     d, stall[d], busy[d], done[d], res[d]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mul_basic(input int d);
        int it = iter_of(d);
        drive_op(d, C_MUL, 32'd3, 32'd5, -1, -1, it + 5);
        for (int c = 0; c < it + 5; c++) begin
            checks++;
            if (obs_stall[c] !== (c <= it)) begin
                errors++;
                $display("FAIL basic_stall d%0d cyc%0d: got %b, required %b", d, c, obs_stall[c], c <= it);
            end
            checks++;
            if (obs_done[c] !== (c == it + 1)) begin
                errors++;
                $display("FAIL basic_done d%0d cyc%0d: got %b, required %b", d, c, obs_done[c], c == it + 1);
            end
            checks++;
            if (obs_busy[c] !== (c >= 1 && c <= it)) begin
                errors++;
                $display("FAIL basic_busy d%0d cyc%0d: got %b, required %b", d, c, obs_busy[c], c >= 1 && c <= it);
            end
        end
        checks++;
        if (obs_res[it + 1] !== 32'd15) begin
            errors++;
            $display("FAIL basic_result d%0d: got %h, required 0000000f", d, obs_res[it + 1]);
        end
    endtask

    task automatic test_mul_op(input int d, input logic [31:0] a, input logic [31:0] b, input string name);
        int lat = latency(d, a, b);
        int n = lat + 3;
        int fd;
        drive_op(d, C_MUL, a, b, -1, -1, n);
        fd = first_done(n);
        checks++;
        if (fd != lat) begin
            errors++;
            $display("FAIL %s_latency d%0d a=%h b=%h: done at %0d, required %0d", name, d, a, b, fd, lat);
        end
        checks++;
        if (count_done(n) != 1) begin
            errors++;
            $display("FAIL %s_done_count d%0d: got %0d, required 1", name, d, count_done(n));
        end
        checks++;
        if (count_stall(n) != lat || obs_stall[0] !== 1'b1) begin
            errors++;
            $display("FAIL %s_stall d%0d: %0d stall cycles (cycle0=%b), required %0d from cycle 0",
                     name, d, count_stall(n), obs_stall[0], lat);
        end
        checks++;
        if (obs_res[lat] !== product(a, b)) begin
            errors++;
            $display("FAIL %s_result d%0d a=%h b=%h: got %h, required %h", name, d, a, b, obs_res[lat], product(a, b));
        end
    endtask

    task automatic test_passthru(input int d);
        logic [2:0] codes [6] = '{C_AND, C_XOR, C_ADD, C_SLL, C_SUB, C_SRAI};
        for (int k = 0; k < 6; k++) begin
            drive_op(d, codes[k], 32'd3, 32'd5, -1, -1, 3);
            for (int c = 0; c < 3; c++) begin
                checks++;
                if ({obs_stall[c], obs_busy[c], obs_done[c]} !== 3'b000) begin
                    errors++;
                    $display("FAIL passthru d%0d code=%b cyc%0d: stall/busy/done=%b%b%b, required 000",
                             d, codes[k], c, obs_stall[c], obs_busy[c], obs_done[c]);
                end
            end
        end
        valid[d] = 1'b0;
        ctl[d]   = C_MUL;
        @(negedge clk);
        checks++;
        if (stall[d] !== 1'b0) begin
            errors++;
            $display("FAIL invalid_mul d%0d: stall=%b, required 0", d, stall[d]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_flush(input int d);
        int it = iter_of(d);
        int fa = (d == 0) ? 10 : 5;
        test_mul_op(d, 32'd11, 32'd13, "preflush");
        drive_op(d, C_MUL, 32'd7, 32'd9, fa, -1, it + 5);
        for (int c = 0; c < it + 5; c++) begin
            checks++;
            if (obs_stall[c] !== (c <= fa)) begin
                errors++;
                $display("FAIL flush_stall d%0d cyc%0d: got %b, required %b", d, c, obs_stall[c], c <= fa);
            end
        end
        checks++;
        if (count_done(it + 5) != 0) begin
            errors++;
            $display("FAIL flush_done d%0d: %0d pulses, required 0", d, count_done(it + 5));
        end
        checks++;
        if (obs_res[it + 4] !== 32'd143 || obs_busy[fa + 1] !== 1'b0) begin
            errors++;
            $display("FAIL flush_hold d%0d: result=%h busy=%b, required 0000008f and 0", d, obs_res[it + 4], obs_busy[fa + 1]);
        end
        test_mul_op(d, 32'd6, 32'd7, "after_flush");
    endtask

    task automatic test_flush_edges(input int d);
        int it = iter_of(d);
        drive_op(d, C_MUL, 32'd7, 32'd9, 0, -1, 4);
        checks++;
        if (obs_stall[0] !== 1'b0 || obs_busy[1] !== 1'b0 || count_done(4) != 0) begin
            errors++;
            $display("FAIL flush_start d%0d: stall0=%b busy1=%b dones=%0d, required 0 0 0",
                     d, obs_stall[0], obs_busy[1], count_done(4));
        end
        drive_op(d, C_MUL, 32'd5, 32'd7, it + 1, -1, it + 4);
        checks++;
        if (obs_done[it + 1] !== 1'b1 || obs_res[it + 1] !== 32'd35) begin
            errors++;
            $display("FAIL flush_in_done d%0d: done=%b result=%h, required 1 and 00000023",
                     d, obs_done[it + 1], obs_res[it + 1]);
        end
    endtask

    task automatic test_reset_mid(input int d);
        drive_op(d, C_MUL, 32'd9, 32'd11, -1, 5, 12);
        checks++;
        if ({obs_stall[6], obs_busy[6], obs_done[6]} !== 3'b000 || obs_res[6] !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid d%0d: stall/busy/done=%b%b%b result=%h, required 000 and 0",
                     d, obs_stall[6], obs_busy[6], obs_done[6], obs_res[6]);
        end
        checks++;
        if (count_done(12) != 0) begin
            errors++;
            $display("FAIL reset_mid_done d%0d: %0d pulses, required 0", d, count_done(12));
        end
        test_mul_op(d, 32'd2, 32'd3, "after_reset");
    endtask

    task automatic test_back_to_back(input int d);
        int it = iter_of(d);
        logic [31:0] ops [2] = '{32'd4, 32'd5};
        int n = 2 * (it + 2) + 4;
        int k = 0, ndone = 0, d1 = -1, d2 = -1;
        logic [31:0] r1 = '0, r2 = '0;
        for (int c = 0; c < n; c++) begin
            valid[d] = (k < 2);
            ctl[d]   = C_MUL;
            a_in[d]  = (k < 2) ? ops[k] : 32'd0;
            b_in[d]  = (k < 2) ? ops[k] : 32'd0;
            flush[d] = 1'b0;
            @(negedge clk);
            obs_stall[c] = stall[d];
            if (done[d] === 1'b1) begin
                ndone++;
                if (k == 0) begin d1 = c; r1 = res[d]; end
                else if (k == 1) begin d2 = c; r2 = res[d]; end
                if (k < 2) k++;
            end
            @(posedge clk);
            #1;
        end
        valid[d] = 1'b0;
        checks++;
        if (ndone != 2) begin
            errors++;
            $display("FAIL b2b_count d%0d: %0d pulses, required 2", d, ndone);
        end
        checks++;
        if (r1 !== 32'd16 || r2 !== 32'd25) begin
            errors++;
            $display("FAIL b2b_results d%0d: got %h %h, required 00000010 00000019", d, r1, r2);
        end
        checks++;
        if (d1 != it + 1 || d2 != d1 + it + 2) begin
            errors++;
            $display("FAIL b2b_timing d%0d: done at %0d and %0d, required %0d and %0d", d, d1, d2, it + 1, 2 * it + 3);
        end
        checks++;
        if (d1 >= 0 && (obs_stall[d1] !== 1'b0 || obs_stall[d1 + 1] !== 1'b1)) begin
            errors++;
            $display("FAIL b2b_stall d%0d: stall in DONE=%b next=%b, required 0 then 1",
                     d, obs_stall[d1], obs_stall[d1 + 1]);
        end
    endtask

    task automatic test_random(input int d);
        logic [2:0] others [6] = '{C_AND, C_XOR, C_ADD, C_SLL, C_SUB, C_SRAI};
        for (int k = 0; k < 20; k++) begin
            logic [31:0] a = $urandom;
            logic [31:0] b = $urandom;
            if ($urandom_range(0, 5) == 0) a = 32'd0;
            if ($urandom_range(0, 5) == 0) b = 32'd0;
            if ($urandom_range(0, 2) == 0) begin
                drive_op(d, others[$urandom_range(0, 5)], a, b, -1, -1, 3);
                checks++;
                if (count_stall(3) != 0 || count_done(3) != 0) begin
                    errors++;
                    $display("FAIL rand_passthru d%0d: stalls=%0d dones=%0d, required 0 0", d, count_stall(3), count_done(3));
                end
            end else begin
                test_mul_op(d, a, b, "rand");
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0;
            valid[d] = 1'b0;
            flush[d] = 1'b0;
            ctl[d]   = C_ADD;
            a_in[d]  = '0;
            b_in[d]  = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) rst_n[d] = 1'b1;
        for (int d = 0; d < 2; d++) begin
            test_reset(d);
            test_mul_basic(d);
            test_mul_op(d, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "allones");
            test_mul_op(d, 32'h8000_0000, 32'd2, "overflow");
            test_mul_op(d, 32'd0, 32'h0000_1234, "zero_a");
            test_mul_op(d, 32'h0000_1234, 32'd0, "zero_b");
            test_passthru(d);
            test_flush(d);
            test_flush_edges(d);
            test_reset_mid(d);
            test_back_to_back(d);
            test_random(d);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Sequencer for a shared iterative multiplier in the EX stage of the pipelined RV32 core.
- When the EX-stage instruction carries ALU control code MUL (3'b101), the block latches the operands and stalls the pipeline while a shift-add datapath runs for WIDTH/BITS_PER_CYCLE iterations.
- It then presents the low WIDTH bits of the product for one release cycle.
- All other ALU codes (AND 000, XOR 001, ADD 010, SLL 011, SUB 110, SRAI 111) pass through with no stall.

Parameters:
- WIDTH, 32, operand and result width.
- BITS_PER_CYCLE, 1, multiplier bits consumed per iteration; legal values 1, 2, 4 (must divide WIDTH).
- ITER (derived), WIDTH/BITS_PER_CYCLE, number of iterations.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-low reset.
- valid_i  in  1  EX stage holds a valid instruction.
- ALUCtl_i  in  3  ALU control code of the EX instruction.
- rs1_data_i  in  WIDTH  multiplicand.
- rs2_data_i  in  WIDTH  multiplier.
- flush_i  in  1  EX instruction squashed (branch taken).
- stall_o  out  1  hold IF/ID/EX and their pipeline registers.
- busy_o  out  1  multiplier occupied.
- done_o  out  1  one-cycle pulse: result_o is valid for the EX instruction.
- result_o  out  WIDTH  low WIDTH bits of rs1*rs2.

Behaviour:
- Reset (rst_i==0 at a clock edge):
  - state=IDLE; counter, accumulator, operand registers and result_o cleared to 0.
  - stall_o=0, busy_o=0, done_o=0.
  - Reset overrides every other input, including mid-operation.
- States: IDLE, BUSY, DONE.
- IDLE:
  - start = valid_i && ALUCtl_i==3'b101 && !flush_i.
  - stall_o = start (combinational, same cycle).
  - On start, latch A=rs1_data_i, B=rs2_data_i, acc=0, cnt=0.
  - If either operand is 0, go to DONE; otherwise go to BUSY.
  - Non-MUL codes, or valid_i==0: no action, stall_o=0.
- BUSY:
  - stall_o=1, busy_o=1.
  - Each cycle: acc += A * B[BITS_PER_CYCLE-1:0] (truncated to WIDTH); A <<= BITS_PER_CYCLE; B >>= BITS_PER_CYCLE; cnt++.
  - After the cycle with cnt==ITER-1, go to DONE.
- DONE (exactly one cycle):
  - stall_o=0, busy_o=0, done_o=1, result_o=acc.
  - Next state is IDLE.
  - A MUL still present on valid_i/ALUCtl_i in this cycle is the same instruction being released; it must not retrigger.
- result_o holds its value until the next DONE or reset.
- Latency with the start cycle = cycle 0:
  - stall_o high for cycles 0..ITER (ITER+1 cycles); DONE in cycle ITER+1 (33 for the defaults).
  - Zero-operand fast path: stall for cycle 0 only; DONE in cycle 1; result 0.
- Arithmetic: low WIDTH bits only, so signed and unsigned operands give the same result (RV32 MUL); carries out of bit WIDTH-1 are discarded.
- Flush in BUSY: return to IDLE next cycle. stall_o is deasserted from that cycle, done_o is not pulsed, result_o is unchanged.
- Flush in the IDLE start cycle: start is suppressed.
- Flush in DONE: no effect; the pulse still occurs and the consumer discards it.
- Back-to-back MULs: a new start is accepted in the IDLE cycle right after DONE, so there is a 1-cycle gap minimum.
- Counter width is clog2(ITER). The counter does not wrap within an operation.

Decomposition:
- Shared package alu_pkg:
  - ALU control code constants ALU_AND, ALU_XOR, ALU_ADD, ALU_SLL, ALU_MUL, ALU_SUB, ALU_SRAI.
  - State encoding for IDLE/BUSY/DONE.
  - Also used by the existing ALU control decoder and the ALU.
- One natural sub-module: mul_shift_add_step. It is combinational: given acc, A and the low BITS_PER_CYCLE bits of B, it returns the next acc. The FSM, counter and registers stay in mul_seq_ctrl.

Test Plan:
- MUL 3*5, defaults:
  - stall_o=1 for cycles 0..32.
  - done_o=1 with result_o=15 in cycle 33.
  - busy_o=0 in cycle 33.
- MUL 0xFFFFFFFF*0xFFFFFFFF -> result_o=0x00000001.
- MUL 0x80000000*2 -> result_o=0 (overflow truncated).
- MUL 0*0x1234 -> stall_o high in cycle 0 only; done_o in cycle 1; result_o=0.
- ADD (ALUCtl 010) with valid_i=1 -> stall_o=0, busy_o=0, done_o never asserted.
- MUL 7*9, flush_i=1 in cycle 10 -> stall_o=0 from cycle 11, no done_o; result_o keeps its prior value. Then MUL 6*7 completes with 42.
- MUL in progress, rst_i=0 in cycle 5 -> next cycle all outputs 0, state IDLE. Then a fresh MUL 2*3 yields 6.
- Back-to-back MUL 4*4 then 5*5 (instruction held through DONE, new one in the next cycle):
  - exactly one done_o per MUL.
  - results 16 and 25.
  - second stall begins the cycle after the first DONE.
- Repeat the directed cases with BITS_PER_CYCLE=4 -> DONE in cycle 9 for nonzero operands; same results.
